lmb_bram_dp_param: RTL and testbench

- Parametrised true dual-port block RAM for MicroBlaze local memory.
- Successor to the fixed 16 KB, four-primitive BRAM block; inferred memory replaces hand-instantiated primitives.
- Adds:
  - configurable width and depth
  - per-port write mode
  - optional output pipeline register
  - post-reset zero-initialise sequencer
  - cross-port write-collision detection and counting
- Sits between two LMB BRAM interface controllers (instruction and data side), same clock domain.

---
 rtl/lmb_bram_dp_param.sv | 265 ++++++++++++++++++++++++++
 tb/tb_lmb_bram_dp_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmb_bram_dp_param.sv
// -----------------------------------------------------------------------------
// lmb_bram_dp_param
// Parametrised true dual-port block RAM for MicroBlaze local memory. Sits
// between the instruction-side and data-side LMB BRAM interface controllers,
// both running on BRAM_Clk.
//
// Features: configurable width/depth, per-port WRITE_FIRST / READ_FIRST mode,
// optional second output register (C_READ_LATENCY = 2), post-reset zero
// initialise sequencer, and cross-port write collision detection/counting.
//
// Ports (A and B are identical):
//   BRAM_Clk      common clock
//   BRAM_Rst_N    asynchronous active-low reset
//   BRAM_Rst_x    synchronous active-high clear of port x output register(s)
//   BRAM_EN_x     port enable
//   BRAM_WEN_x    byte write enables, bit 0 = byte [0:7] (most significant)
//   BRAM_Addr_x   byte address, big-endian bit numbering
//   BRAM_Dout_x   write data from controller
//   BRAM_Din_x    read data to controller
//   Init_Busy     high while the zero-initialise sequence runs
//   Collision     one-cycle pulse after a cross-port overlapping write
//   Coll_Cnt      saturating collision count
// -----------------------------------------------------------------------------
module lmb_bram_dp_param #(
    parameter int    C_MEMSIZE      = 'h4000,
    parameter int    C_PORT_DWIDTH  = 32,
    parameter int    C_PORT_AWIDTH  = 32,
    parameter int    C_NUM_WE       = C_PORT_DWIDTH / 8,
    parameter int    C_READ_LATENCY = 1,
    parameter string C_WRITE_MODE_A = "WRITE_FIRST",
    parameter string C_WRITE_MODE_B = "WRITE_FIRST",
    parameter int    C_INIT_ZERO    = 1
) (
    input  logic                     BRAM_Clk,
    input  logic                     BRAM_Rst_N,
    input  logic                     BRAM_Rst_A,
    input  logic                     BRAM_EN_A,
    input  logic [0:C_NUM_WE-1]      BRAM_WEN_A,
    input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Din_A,
    input  logic                     BRAM_Rst_B,
    input  logic                     BRAM_EN_B,
    input  logic [0:C_NUM_WE-1]      BRAM_WEN_B,
    input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Din_B,
    output logic                     Init_Busy,
    output logic                     Collision,
    output logic [15:0]              Coll_Cnt
);

    localparam int DW     = C_PORT_DWIDTH;
    localparam int BYTES  = C_PORT_DWIDTH / 8;
    localparam int LSB    = $clog2(BYTES);
    localparam int IDX_W  = $clog2(C_MEMSIZE / BYTES);
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int IDX_LO = C_PORT_AWIDTH - LSB - IDX_W;
    localparam int IDX_HI = C_PORT_AWIDTH - LSB - 1;
    localparam bit WF_A   = (C_WRITE_MODE_A == "WRITE_FIRST");
    localparam bit WF_B   = (C_WRITE_MODE_B == "WRITE_FIRST");

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (C_INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    // Replace the byte lanes selected by wen (lane 0 = most significant byte).
    function automatic logic [DW-1:0] lane_merge(
        input logic [DW-1:0]       old_word,
        input logic [DW-1:0]       new_word,
        input logic [0:C_NUM_WE-1] wen
    );
        logic [DW-1:0] res;
        res = old_word;
        for (int k = 0; k < C_NUM_WE; k++) begin
            if (wen[k]) begin
                res[DW-1-8*k -: 8] = new_word[DW-1-8*k -: 8];
            end
        end
        return res;
    endfunction

    logic [DW-1:0]    mem_r [DEPTH];
    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] init_cnt_r;
    logic [IDX_W-1:0] init_cnt_next_s;
    logic             busy_r;
    logic             run_s;

    logic [IDX_W-1:0] idx_a_s;
    logic [IDX_W-1:0] idx_b_s;
    logic [DW-1:0]    wdata_a_s;
    logic [DW-1:0]    wdata_b_s;
    logic [DW-1:0]    rd_a_s;
    logic [DW-1:0]    rd_b_s;

    logic [DW-1:0]    dout1_a_r;
    logic [DW-1:0]    dout2_a_r;
    logic             en_d_a_r;
    logic [DW-1:0]    dout1_b_r;
    logic [DW-1:0]    dout2_b_r;
    logic             en_d_b_r;

    logic             coll_s;
    logic             coll_r;
    logic [15:0]      coll_cnt_r;
    logic             unused_addr_s;

    // Upper address bits alias; byte-offset bits are below word granularity.
    assign idx_a_s       = BRAM_Addr_A[IDX_LO:IDX_HI];
    assign idx_b_s       = BRAM_Addr_B[IDX_LO:IDX_HI];
    assign unused_addr_s = ^{BRAM_Addr_A, BRAM_Addr_B};
    assign wdata_a_s     = BRAM_Dout_A;
    assign wdata_b_s     = BRAM_Dout_B;
    assign run_s         = (state_r == ST_RUN);

    // State, init counter and busy flag registers.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            state_r    <= RESET_STATE;
            init_cnt_r <= '0;
            busy_r     <= (C_INIT_ZERO != 0) ? 1'b1 : 1'b0;
        end else begin
            state_r    <= state_next_s;
            init_cnt_r <= init_cnt_next_s;
            busy_r     <= (state_next_s == ST_INIT);
        end
    end

    // Next-state logic: INIT sweeps every word once, then RUN forever.
    always_comb begin
        state_next_s    = state_r;
        init_cnt_next_s = init_cnt_r;
        case (state_r)
            ST_INIT: begin
                init_cnt_next_s = init_cnt_r + IDX_W'(1);
                if (init_cnt_r == {IDX_W{1'b1}}) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = RESET_STATE;
            end
        endcase
    end

    // Memory array: zero sweep during INIT, byte-lane writes in RUN.
    // Port A lanes are written last so A wins on overlapping lanes.
    always_ff @(posedge BRAM_Clk) begin
        if (state_r == ST_INIT) begin
            mem_r[init_cnt_r] <= '0;
        end else begin
            for (int k = 0; k < C_NUM_WE; k++) begin
                if (BRAM_EN_B && BRAM_WEN_B[k]) begin
                    mem_r[idx_b_s][DW-1-8*k -: 8] <= wdata_b_s[DW-1-8*k -: 8];
                end
            end
            for (int k = 0; k < C_NUM_WE; k++) begin
                if (BRAM_EN_A && BRAM_WEN_A[k]) begin
                    mem_r[idx_a_s][DW-1-8*k -: 8] <= wdata_a_s[DW-1-8*k -: 8];
                end
            end
        end
    end

    // Read data: own written lanes bypass in WRITE_FIRST; the other port's
    // write is never visible in the same cycle (read-before-write across ports).
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        if (WF_A) begin
            rd_a_s = lane_merge(mem_r[idx_a_s], wdata_a_s, BRAM_WEN_A);
        end else begin
            rd_a_s = mem_r[idx_a_s];
        end
        if (WF_B) begin
            rd_b_s = lane_merge(mem_r[idx_b_s], wdata_b_s, BRAM_WEN_B);
        end else begin
            rd_b_s = mem_r[idx_b_s];
        end
    end

    // Port A output registers: held at zero during INIT, sync clear wins over load.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            dout1_a_r <= '0;
            dout2_a_r <= '0;
            en_d_a_r  <= 1'b0;
        end else if (!run_s) begin
            dout1_a_r <= '0;
            dout2_a_r <= '0;
            en_d_a_r  <= 1'b0;
        end else if (BRAM_Rst_A) begin
            dout1_a_r <= '0;
            dout2_a_r <= '0;
            en_d_a_r  <= BRAM_EN_A;
        end else begin
            en_d_a_r <= BRAM_EN_A;
            if (BRAM_EN_A) begin
                dout1_a_r <= rd_a_s;
            end
            if (en_d_a_r) begin
                dout2_a_r <= dout1_a_r;
            end
        end
    end

    // Port B output registers: same structure as port A.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            dout1_b_r <= '0;
            dout2_b_r <= '0;
            en_d_b_r  <= 1'b0;
        end else if (!run_s) begin
            dout1_b_r <= '0;
            dout2_b_r <= '0;
            en_d_b_r  <= 1'b0;
        end else if (BRAM_Rst_B) begin
            dout1_b_r <= '0;
            dout2_b_r <= '0;
            en_d_b_r  <= BRAM_EN_B;
        end else begin
            en_d_b_r <= BRAM_EN_B;
            if (BRAM_EN_B) begin
                dout1_b_r <= rd_b_s;
            end
            if (en_d_b_r) begin
                dout2_b_r <= dout1_b_r;
            end
        end
    end

    // A collision needs both ports writing at least one common lane of one word.
    assign coll_s = run_s && BRAM_EN_A && BRAM_EN_B && (idx_a_s == idx_b_s)
                    && (|(BRAM_WEN_A & BRAM_WEN_B));

    // Collision pulse and saturating counter.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            coll_r     <= 1'b0;
            coll_cnt_r <= 16'h0000;
        end else begin
            coll_r <= coll_s;
            if (coll_s && (coll_cnt_r != 16'hFFFF)) begin
                coll_cnt_r <= coll_cnt_r + 16'd1;
            end
        end
    end

    assign BRAM_Din_A = (C_READ_LATENCY == 2) ? dout2_a_r : dout1_a_r;
    assign BRAM_Din_B = (C_READ_LATENCY == 2) ? dout2_b_r : dout1_b_r;
    assign Init_Busy  = busy_r;
    assign Collision  = coll_r;
    assign Coll_Cnt   = coll_cnt_r;

endmodule

// File: tb/tb_lmb_bram_dp_param.sv
// -----------------------------------------------------------------------------
// tb_lmb_bram_dp_param
// Directed bench for lmb_bram_dp_param. Two instances share all inputs:
//   dut0 - default parameters (WRITE_FIRST both ports, latency 1)
//   dut1 - port A READ_FIRST, latency 2
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_lmb_bram_dp_param;

    logic        clk;
    logic        rst_n;
    logic        rst_a;
    logic        rst_b;
    logic        en_a;
    logic [0:3]  wen_a;
    logic [0:31] addr_a;
    logic [0:31] wdat_a;
    logic        en_b;
    logic [0:3]  wen_b;
    logic [0:31] addr_b;
    logic [0:31] wdat_b;

    logic [0:31] din_a0;
    logic [0:31] din_b0;
    logic        busy0;
    logic        coll0;
    logic [15:0] cnt0;
    logic [0:31] din_a1;
    logic [0:31] din_b1;
    logic        busy1;
    logic        coll1;
    logic [15:0] cnt1;

    int n_cmp;
    int n_err;

    lmb_bram_dp_param dut0 (
        .BRAM_Clk   (clk),
        .BRAM_Rst_N (rst_n),
        .BRAM_Rst_A (rst_a),
        .BRAM_EN_A  (en_a),
        .BRAM_WEN_A (wen_a),
        .BRAM_Addr_A(addr_a),
        .BRAM_Dout_A(wdat_a),
        .BRAM_Din_A (din_a0),
        .BRAM_Rst_B (rst_b),
        .BRAM_EN_B  (en_b),
        .BRAM_WEN_B (wen_b),
        .BRAM_Addr_B(addr_b),
        .BRAM_Dout_B(wdat_b),
        .BRAM_Din_B (din_b0),
        .Init_Busy  (busy0),
        .Collision  (coll0),
        .Coll_Cnt   (cnt0)
    );

    lmb_bram_dp_param #(
        .C_READ_LATENCY(2),
        .C_WRITE_MODE_A("READ_FIRST")
    ) dut1 (
        .BRAM_Clk   (clk),
        .BRAM_Rst_N (rst_n),
        .BRAM_Rst_A (rst_a),
        .BRAM_EN_A  (en_a),
        .BRAM_WEN_A (wen_a),
        .BRAM_Addr_A(addr_a),
        .BRAM_Dout_A(wdat_a),
        .BRAM_Din_A (din_a1),
        .BRAM_Rst_B (rst_b),
        .BRAM_EN_B  (en_b),
        .BRAM_WEN_B (wen_b),
        .BRAM_Addr_B(addr_b),
        .BRAM_Dout_B(wdat_b),
        .BRAM_Din_B (din_b1),
        .Init_Busy  (busy1),
        .Collision  (coll1),
        .Coll_Cnt   (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic [0:3] wen, input logic [0:31] addr,
                           input logic [0:31] data);
        en_a = en; wen_a = wen; addr_a = addr; wdat_a = data;
    endtask

    task automatic drive_b(input logic en, input logic [0:3] wen, input logic [0:31] addr,
                           input logic [0:31] data);
        en_b = en; wen_b = wen; addr_b = addr; wdat_b = data;
    endtask

    task automatic idle();
        drive_a(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_b(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    initial begin
        int cyc;
        logic din_nz;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle();
        repeat (3) tick();

        // Reset state
        check_val("rst_din_a", din_a0, 32'h0);
        check_val("rst_din_b", din_b0, 32'h0);
        check_val("rst_busy", {31'h0, busy0}, 32'h1);
        check_val("rst_coll", {31'h0, coll0}, 32'h0);
        check_val("rst_cnt", {16'h0, cnt0}, 32'h0);

        // Reset in the middle of INIT
        rst_n = 1'b1;
        repeat (1000) tick();
        check_val("mid_init_busy", {31'h0, busy0}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_din", din_a0, 32'h0);
        check_val("mid_rst_busy", {31'h0, busy0}, 32'h1);
        tick();
        rst_n = 1'b1;

        // Full INIT with port A trying to write; the writes must be ignored
        drive_a(1'b1, 4'b1111, 32'h0000_3FFC, 32'hFFFF_FFFF);
        cyc = 0;
        din_nz = 1'b0;
        while (busy0 && cyc < 5000) begin
            tick();
            cyc++;
            if (din_a0 != 32'h0) din_nz = 1'b1;
        end
        idle();
        check_val("init_len", cyc, 32'd4096);
        check_val("init_din_hold", {31'h0, din_nz}, 32'h0);
        check_val("init_busy1", {31'h0, busy1}, 32'h0);

        // Zero-initialised top word
        drive_a(1'b1, 4'b0000, 32'h0000_3FFC, 32'h0);
        tick();
        check_val("zero_top", din_a0, 32'h0);
        idle();
        tick();

        // Byte-lane writes
        drive_a(1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF);
        tick();
        check_val("wf_full", din_a0, 32'hDEAD_BEEF);
        drive_a(1'b1, 4'b0001, 32'h10, 32'h0000_00AA);
        tick();
        check_val("wf_lane", din_a0, 32'hDEAD_BEAA);
        check_val("lat2_not_yet", din_a1, 32'h0);
        idle();
        tick();
        check_val("rf_lat2", din_a1, 32'hDEAD_BEEF);
        tick();
        check_val("lat2_hold", din_a1, 32'hDEAD_BEEF);

        drive_b(1'b1, 4'b0000, 32'h10, 32'h0);
        tick();
        check_val("b_read", din_b0, 32'hDEAD_BEAA);
        check_val("b_lat2_early", din_b1, 32'h0);
        idle();
        tick();
        check_val("b_lat2", din_b1, 32'hDEAD_BEAA);

        // Write mode
        drive_a(1'b1, 4'b1111, 32'h20, 32'h1111_1111);
        tick();
        idle();
        tick();
        drive_a(1'b1, 4'b1111, 32'h20, 32'h2222_2222);
        tick();
        check_val("wf_mode", din_a0, 32'h2222_2222);
        idle();
        tick();
        check_val("rf_mode", din_a1, 32'h1111_1111);

        // Sync port reset beats load; array write still happens
        rst_a = 1'b1;
        drive_a(1'b1, 4'b1111, 32'h20, 32'h3333_3333);
        tick();
        rst_a = 1'b0;
        idle();
        check_val("rst_a_din0", din_a0, 32'h0);
        check_val("rst_a_din1", din_a1, 32'h0);
        check_val("rst_a_b_hold", din_b0, 32'hDEAD_BEAA);
        tick();
        drive_a(1'b1, 4'b0000, 32'h20, 32'h0);
        tick();
        check_val("rst_a_wr", din_a0, 32'h3333_3333);
        idle();
        tick();

        // Cross-port collision
        drive_a(1'b1, 4'b1111, 32'h40, 32'h1234_5678);
        tick();
        drive_a(1'b1, 4'b1100, 32'h40, 32'hAAAA_AAAA);
        drive_b(1'b1, 4'b0110, 32'h40, 32'hBBBB_BBBB);
        tick();
        check_val("coll_pulse", {31'h0, coll0}, 32'h1);
        check_val("coll_cnt", {16'h0, cnt0}, 32'h1);
        check_val("coll_cnt1", {16'h0, cnt1}, 32'h1);
        check_val("coll_din_a", din_a0, 32'hAAAA_5678);
        idle();
        tick();
        check_val("coll_end", {31'h0, coll0}, 32'h0);
        drive_a(1'b1, 4'b0000, 32'h40, 32'h0);
        tick();
        check_val("coll_word", din_a0, 32'hAAAA_BB78);

        // Writer vs reader: old data, no collision
        drive_a(1'b1, 4'b0011, 32'h40, 32'h0000_CCDD);
        drive_b(1'b1, 4'b0000, 32'h40, 32'h0);
        tick();
        check_val("rbw_b", din_b0, 32'hAAAA_BB78);
        check_val("rbw_no_coll", {31'h0, coll0}, 32'h0);
        // Both writing disjoint lanes: no collision, both lanes land
        drive_a(1'b1, 4'b1000, 32'h40, 32'h1100_0000);
        drive_b(1'b1, 4'b0001, 32'h40, 32'h0000_00EE);
        tick();
        check_val("disj_no_coll", {31'h0, coll0}, 32'h0);
        idle();
        tick();
        drive_a(1'b1, 4'b0000, 32'hFFFF_C040, 32'h0);
        tick();
        check_val("disj_alias", din_a0, 32'h11AA_CCEE);
        check_val("disj_cnt", {16'h0, cnt0}, 32'h1);

        // Second collision via an aliased address on port B
        drive_a(1'b1, 4'b0001, 32'h40, 32'h0000_0077);
        drive_b(1'b1, 4'b0001, 32'h8040, 32'h0000_0088);
        tick();
        check_val("coll2_pulse", {31'h0, coll0}, 32'h1);
        check_val("coll2_cnt", {16'h0, cnt0}, 32'h2);
        idle();
        tick();
        drive_a(1'b1, 4'b0000, 32'h40, 32'h0);
        tick();
        check_val("coll2_word", din_a0, 32'h11AA_CC77);
        idle();
        tick();

        // Async reset in RUN clears outputs and counter, restarts INIT
        rst_n = 1'b0;
        #1;
        check_val("rerst_din", din_a0, 32'h0);
        check_val("rerst_cnt", {16'h0, cnt0}, 32'h0);
        check_val("rerst_busy", {31'h0, busy0}, 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
